uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
- Parametrised, oversampling successor to the packet UART receiver.
- Receives one start bit (0), WIDTH data bits LSB-first and one stop bit (1). The MSB of the WIDTH field is the packet parity bit.
- Adds configurable oversampling, mid-bit majority voting, false-start rejection, stop-bit framing check, selectable parity sense, a valid/ready output handshake and overrun detection.
- Sits between the chip's serial input pin and the packet FIFO / config-register decoder.

Parameters:
- WIDTH, 64, frame payload bits including the parity bit (MSB). Legal range is 2 to 128.
- OVERSAMPLE, 2, clk cycles per bit. Legal values are 1, 2, 4, 8 or 16.
- PARITY_ODD, 1, parity sense: 1 = odd (total ones in the payload are odd), 0 = even.

Ports:
- clk  input  1  receive clock.
- reset  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line; idles high.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- err_clr  input  1  clears the sticky overrun_error.
- rx_data  output  WIDTH-1  received payload without the parity bit.
- rx_valid  output  1  rx_data holds an unconsumed frame.
- parity_error  output  1  parity result of the frame in rx_data; valid while rx_valid=1.
- framing_error  output  1  stop bit of the frame in rx_data sampled 0; valid while rx_valid=1.
- overrun_error  output  1  sticky: a frame was dropped.
- rx_busy  output  1  high from start-bit detect until the stop sample.

Behaviour:
- Reset (clk edge with reset=1):
  - State goes to IDLE and the synchroniser flops are set to 1.
  - rx_data=0, rx_valid=0, parity_error=0, framing_error=0, overrun_error=0, rx_busy=0, all counters 0.
  - Reset mid-frame abandons the frame with no output.
- Synchroniser: rx_in passes through 2 flops; all decisions use the synchronised bit rxs.
- Counters:
  - Sample counter scnt has width max(1,$clog2(OVERSAMPLE)) and runs 0..OVERSAMPLE-1.
  - MID = OVERSAMPLE/2 (integer division).
  - Bit counter bcnt has width $clog2(WIDTH+1).
- Bit sampling:
  - OVERSAMPLE>=4: the bit value is the majority of rxs at scnt = MID-1, MID and MID+1; the decision is taken at MID+1.
  - OVERSAMPLE<4: single sample at MID.
  - "Decision point" below means the MID+1 or MID cycle respectively.
- FSM, state enum IDLE, START, DATA, STOP:
  - IDLE: on rxs=0, go to START with scnt=1 (the detect cycle counts as sample 0) and rx_busy=1.
  - START: at the decision point, a sampled 1 is a false start: return to IDLE, no output, no error. A sampled 0 continues. At scnt=OVERSAMPLE-1, go to DATA with scnt=0 and bcnt=0.
    - If OVERSAMPLE=1, START lasts zero cycles: IDLE goes directly to DATA and there is no false-start rejection.
  - DATA: at each decision point, shift the voted bit into shreg[bcnt]. At scnt=OVERSAMPLE-1, increment bcnt. After bit WIDTH-1 completes, go to STOP.
  - STOP: at the decision point, latch the frame as described below, then go to IDLE immediately, without waiting for the end of the stop bit. This allows back-to-back frames.
- Frame latch, on the cycle after the stop decision point:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in that same cycle:
    - rx_data <= shreg[WIDTH-2:0] and rx_valid <= 1.
    - framing_error <= ~stop_bit.
    - parity_error <= (^shreg[WIDTH-1:0]) != PARITY_ODD.
  - Otherwise the new frame is dropped: old rx_data and flags are retained and overrun_error <= 1.
- Handshake:
  - rx_valid falls the cycle after rx_valid & rx_ready, unless a new frame is latched in that same cycle.
  - rx_data and the error flags are stable while rx_valid=1.
- err_clr clears overrun_error. If err_clr and a new overrun coincide, the set wins.
- Latency: rx_valid rises 1 clk after the stop-bit decision point, i.e. roughly 2 + (WIDTH+1.5)*OVERSAMPLE clk after the rx_in falling edge.
- A line held low continuously produces a frame with framing_error=1. Re-detection requires rxs=0 again in IDLE.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t.
  - Function maj3.
  - Localparam helper for MID.
- One sub-module, uart_rx_sampler: the 2-flop synchroniser, the scnt counter and the majority vote. It outputs rxs, a bit_strobe (decision point) and a bit_end (scnt=OVERSAMPLE-1).

Test Plan:
- WIDTH=64, OVERSAMPLE=4, rx_ready=1; send payload 63'h0 with parity bit 1 -> rx_valid pulses, rx_data=63'h0, parity_error=0, framing_error=0.
- Same frame with parity bit 0 -> rx_data=63'h0, parity_error=1. Same frame with PARITY_ODD=0 -> parity_error=0.
- OVERSAMPLE=4: a 1-clk low glitch on rx_in while idle -> no rx_busy beyond START, rx_valid stays 0. Then send 63'h7FFF_FFFF_FFFF_FFFF with parity 0 -> rx_data matches, parity_error=0.
- Stop bit forced 0 on payload 63'h5 (parity 1) -> rx_data=63'h5, framing_error=1; the next correct frame has framing_error=0.
- rx_ready=0; two back-to-back frames 63'h1 then 63'h2 -> rx_data stays 63'h1 and overrun_error=1. After an err_clr pulse and a rx_ready pulse, overrun_error=0 and rx_valid=0.
- reset=1 asserted at bit 30 of a frame -> all outputs 0 the next cycle. A frame sent after reset is received correctly; repeat with OVERSAMPLE=1 and OVERSAMPLE=16.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and helpers for the
// oversampling UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int MIN_VOTE_OS = 4;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic int uart_mid(input int os);
    return os / 2;
  endfunction

  function automatic int uart_scnt_w(input int os);
    return (os > 1) ? $clog2(os) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: input synchroniser, per-bit sample
// counter and mid-bit majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  input  logic clr_i,
  output logic rxs_o,
  output logic bit_o,
  output logic strobe_o,
  output logic end_o
);

  localparam int SW  = uart_scnt_w(OVERSAMPLE);
  localparam int MID = uart_mid(OVERSAMPLE);
  localparam logic [SW-1:0] SLAST =
    SW'(OVERSAMPLE - 1);

  logic [1:0]    sync_q;
  logic [SW-1:0] scnt_q;
  logic [SW-1:0] scnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  assign rxs_o = sync_q[1];

  always_comb begin
    scnt_d = scnt_q + SW'(1);
    if (clr_i || (scnt_q == SLAST)) begin
      scnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
    end
  end

  assign end_o = (scnt_q == SLAST);

  // Vote over MID-1, MID, MID+1; decide on MID+1.
  if (OVERSAMPLE >= MIN_VOTE_OS) begin : g_vote
    localparam logic [SW-1:0] SDEC =
      SW'(MID + 1);
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        hist_q <= 2'b11;
      end else begin
        hist_q <= {hist_q[0], rxs_o};
      end
    end

    assign strobe_o = (scnt_q == SDEC);
    assign bit_o =
      maj3(hist_q[1], hist_q[0], rxs_o);
  end else begin : g_single
    localparam logic [SW-1:0] SDEC = SW'(MID);
    assign strobe_o = (scnt_q == SDEC);
    assign bit_o    = rxs_o;
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART frame receiver with
// parity/framing flags, valid/ready output and overrun.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int OVERSAMPLE = 2,
  parameter int PARITY_ODD = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  input  logic             rx_ready,
  input  logic             err_clr,
  output logic [WIDTH-2:0] rx_data,
  output logic             rx_valid,
  output logic             parity_error,
  output logic             framing_error,
  output logic             overrun_error,
  output logic             rx_busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BLAST =
    BW'(WIDTH - 1);
  localparam logic PODD = (PARITY_ODD != 0);

  uart_rx_state_t   state_q;
  logic [BW-1:0]    bcnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-2:0] data_q;
  logic             valid_q;
  logic             perr_q;
  logic             ferr_q;
  logic             ovr_q;
  logic             busy_q;

  logic rxs;
  logic vbit;
  logic strobe;
  logic bend;
  logic clr;
  logic accept;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_smp (
    .clk     (clk),
    .reset   (reset),
    .rx_i    (rx_in),
    .clr_i   (clr),
    .rxs_o   (rxs),
    .bit_o   (vbit),
    .strobe_o(strobe),
    .end_o   (bend)
  );

  // Sample counter restarts whenever we sit in or fall back to IDLE.
  assign clr =
    ((state_q == IDLE) && rxs) ||
    ((state_q == START) && strobe && vbit) ||
    ((state_q == STOP) && strobe);

  assign accept = !valid_q || rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
      if (err_clr) begin
        ovr_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (!rxs) begin
            busy_q  <= 1'b1;
            bcnt_q  <= '0;
            state_q <= (OVERSAMPLE == 1) ?
                       DATA : START;
          end
        end
        START: begin
          if (strobe && vbit) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (bend) begin
            bcnt_q  <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (strobe) begin
            shreg_q <= {vbit, shreg_q[WIDTH-1:1]};
          end
          if (bend) begin
            if (bcnt_q == BLAST) begin
              bcnt_q  <= '0;
              state_q <= STOP;
            end else begin
              bcnt_q <= bcnt_q + BW'(1);
            end
          end
        end
        STOP: begin
          if (strobe) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (accept) begin
              data_q  <= shreg_q[WIDTH-2:0];
              valid_q <= 1'b1;
              ferr_q  <= ~vbit;
              perr_q  <= ((^shreg_q) != PODD);
            end else begin
              ovr_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign overrun_error = ovr_q;
  assign rx_busy       = busy_q;

endmodule
